control_unit_blk: RTL and testbench

Registered, parametrised decode/control stage for the ARM pipeline. It adds block transfers (LDM/STM) that the single-cycle control path lacks: a register list is expanded into one memory beat per set bit, and the stage stalls upstream while beats are pending. Control outputs are registered (1-cycle latency). The stage honours hazard freeze and branch flush.

---
 rtl/control_unit_blk.sv | 218 +++++++++++++++++++++
 tb/tb_control_unit_blk.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_blk.sv
// control_unit_blk: registered decode/control stage for the ARM pipeline.
// Decodes arithmetic, single memory, branch and block (LDM/STM) instructions
// into a registered control word (1-cycle latency). A block transfer is
// expanded into one memory beat per set bit of reg_list, lowest index first;
// busy stays high while beats are still pending so upstream holds its
// instruction.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   freeze            hazard stall: every register holds
//   flush             branch taken: stage contents are killed
//   valid_in, S, mode, OP, blk, reg_list   instruction fields
//   valid_out, SR_update, with_src1, MEM_R, MEM_W, WB_EN, B, EX_CMD
//                     registered control word
//   blk_reg, blk_off  register index and byte offset of the current beat
//   busy              block beats pending
module control_unit_blk #(
  parameter int REG_LIST_W = 16,
  parameter int IDX_W      = $clog2(REG_LIST_W),
  parameter int OFF_W      = IDX_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  S,
  input  logic [1:0]            mode,
  input  logic [3:0]            OP,
  input  logic                  blk,
  input  logic [REG_LIST_W-1:0] reg_list,
  output logic                  valid_out,
  output logic                  SR_update,
  output logic                  with_src1,
  output logic                  MEM_R,
  output logic                  MEM_W,
  output logic                  WB_EN,
  output logic                  B,
  output logic [3:0]            EX_CMD,
  output logic [IDX_W-1:0]      blk_reg,
  output logic [OFF_W-1:0]      blk_off,
  output logic                  busy
);

  typedef enum logic {IDLE, BLK} state_t;

  state_t                  state_q, state_d;
  logic [REG_LIST_W-1:0]   rem_q, rem_d;   // registers still to transfer
  logic [IDX_W-1:0]        cnt_q, cnt_d;   // ordinal of the next beat
  logic                    ld_q, ld_d;     // captured load/store direction

  logic                    valid_d, sr_d, src1_d, mem_r_d, mem_w_d, wb_d, b_d, busy_d;
  logic [3:0]              cmd_d;
  logic [IDX_W-1:0]        reg_d;
  logic [OFF_W-1:0]        off_d;

  // Lowest set bit of the list being walked: the incoming list when idle,
  // the captured remainder while in BLK.
  logic [REG_LIST_W-1:0]   src;
  logic [REG_LIST_W-1:0]   rest;
  logic [IDX_W-1:0]        low_idx;

  assign src = (state_q == BLK) ? rem_q : reg_list;

  always_comb begin
    low_idx = '0;
    // Scan downward so the final hit is the lowest set bit.
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (src[i]) low_idx = IDX_W'(i);
    end
  end

  assign rest = src & ~(REG_LIST_W'(1) << low_idx);

  // Arithmetic opcode table.
  logic       arith_ok, arith_wb;
  logic [3:0] arith_cmd;

  always_comb begin
    arith_ok  = 1'b1;
    arith_wb  = 1'b1;
    arith_cmd = 4'b0000;
    case (OP)
      4'b1101: arith_cmd = 4'b0001;                    // MOV
      4'b1111: arith_cmd = 4'b1001;                    // MVN
      4'b0100: arith_cmd = 4'b0010;                    // ADD
      4'b0101: arith_cmd = 4'b0011;                    // ADC
      4'b0010: arith_cmd = 4'b0100;                    // SUB
      4'b0110: arith_cmd = 4'b0101;                    // SBC
      4'b0000: arith_cmd = 4'b0110;                    // AND
      4'b1100: arith_cmd = 4'b0111;                    // ORR
      4'b0001: arith_cmd = 4'b1000;                    // EOR
      4'b1010: begin arith_cmd = 4'b0100; arith_wb = 1'b0; end  // CMP
      4'b1000: begin arith_cmd = 4'b0110; arith_wb = 1'b0; end  // TST
      default: begin arith_ok = 1'b0; arith_wb = 1'b0; end
    endcase
  end

  // Next-state and next control word.
  always_comb begin
    state_d = IDLE;
    rem_d   = '0;
    cnt_d   = '0;
    ld_d    = ld_q;
    valid_d = 1'b0;
    sr_d    = 1'b0;
    src1_d  = 1'b0;
    mem_r_d = 1'b0;
    mem_w_d = 1'b0;
    wb_d    = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b0;
    cmd_d   = 4'b0000;
    reg_d   = '0;
    off_d   = '0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          case (mode)
            2'b00: begin
              if (arith_ok) begin
                valid_d = 1'b1;
                sr_d    = S;
                src1_d  = !(OP == 4'b1101 || OP == 4'b1111);
                wb_d    = arith_wb;
                cmd_d   = arith_cmd;
              end
            end
            2'b01: begin
              // Single transfer, or first beat of a non-empty block list.
              if (!blk || (|reg_list)) begin
                valid_d = 1'b1;
                src1_d  = 1'b1;
                cmd_d   = 4'b0010;
                mem_r_d = S;
                wb_d    = S;
                mem_w_d = !S;
              end
              if (blk && (|reg_list)) begin
                reg_d = low_idx;
                ld_d  = S;
                if (|rest) begin
                  state_d = BLK;
                  busy_d  = 1'b1;
                  rem_d   = rest;
                  cnt_d   = IDX_W'(1);
                end
              end
            end
            2'b10: begin
              valid_d = 1'b1;
              b_d     = 1'b1;
            end
            default: ;
          endcase
        end
      end

      BLK: begin
        valid_d = 1'b1;
        src1_d  = 1'b1;
        cmd_d   = 4'b0010;
        mem_r_d = ld_q;
        wb_d    = ld_q;
        mem_w_d = !ld_q;
        reg_d   = low_idx;
        // 4*k wraps naturally at the OFF_W boundary.
        off_d   = OFF_W'(cnt_q) << 2;
        if (|rest) begin
          state_d = BLK;
          busy_d  = 1'b1;
          rem_d   = rest;
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      ld_q      <= 1'b0;
      valid_out <= 1'b0;
      SR_update <= 1'b0;
      with_src1 <= 1'b0;
      MEM_R     <= 1'b0;
      MEM_W     <= 1'b0;
      WB_EN     <= 1'b0;
      B         <= 1'b0;
      EX_CMD    <= 4'b0000;
      blk_reg   <= '0;
      blk_off   <= '0;
      busy      <= 1'b0;
    end else if (!freeze) begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      ld_q      <= ld_d;
      valid_out <= valid_d;
      SR_update <= sr_d;
      with_src1 <= src1_d;
      MEM_R     <= mem_r_d;
      MEM_W     <= mem_w_d;
      WB_EN     <= wb_d;
      B         <= b_d;
      EX_CMD    <= cmd_d;
      blk_reg   <= reg_d;
      blk_off   <= off_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_control_unit_blk.sv
// Randomised bench for control_unit_blk against a beat-queue reference model.
module tb_control_unit_blk;
  localparam int W  = 16;
  localparam int IW = $clog2(W);
  localparam int OW = IW + 2;
  localparam int WD = 7 + 4 + IW + OW;

  typedef logic [WD-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst, freeze, flush, valid_in, S, blk;
  logic [1:0]    mode;
  logic [3:0]    OP;
  logic [W-1:0]  reg_list;
  logic          valid_out, SR_update, with_src1, MEM_R, MEM_W, WB_EN, B, busy;
  logic [3:0]    EX_CMD;
  logic [IW-1:0] blk_reg;
  logic [OW-1:0] blk_off;

  control_unit_blk #(.REG_LIST_W(W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .S(S), .mode(mode), .OP(OP), .blk(blk), .reg_list(reg_list),
    .valid_out(valid_out), .SR_update(SR_update), .with_src1(with_src1),
    .MEM_R(MEM_R), .MEM_W(MEM_W), .WB_EN(WB_EN), .B(B), .EX_CMD(EX_CMD),
    .blk_reg(blk_reg), .blk_off(blk_off), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic word_t mk(input bit v, sr, s1, mr, mw, wb, b,
                               input logic [3:0] cmd, input int r, input int k);
    return {v, sr, s1, mr, mw, wb, b, cmd, IW'(r), OW'(4 * k)};
  endfunction

  // Reference model: the current control word plus a queue of beats still
  // owed by an accepted block transfer. busy == queue not empty.
  word_t cur = '0;
  word_t pend[$];

  task automatic model_edge();
    logic [3:0] c;
    bit         wb, ok;
    int         k;
    if (!rst || flush) begin
      cur = '0;
      pend.delete();
    end else if (freeze) begin
      // hold
    end else if (pend.size() != 0) begin
      cur = pend.pop_front();
    end else begin
      cur = '0;
      if (valid_in) begin
        case (mode)
          2'b00: begin
            ok = 1; wb = 1; c = 4'b0000;
            case (OP)
              4'b1101: c = 4'b0001;
              4'b1111: c = 4'b1001;
              4'b0100: c = 4'b0010;
              4'b0101: c = 4'b0011;
              4'b0010: c = 4'b0100;
              4'b0110: c = 4'b0101;
              4'b0000: c = 4'b0110;
              4'b1100: c = 4'b0111;
              4'b0001: c = 4'b1000;
              4'b1010: begin c = 4'b0100; wb = 0; end
              4'b1000: begin c = 4'b0110; wb = 0; end
              default: ok = 0;
            endcase
            if (ok) cur = mk(1, S, !(OP == 4'b1101 || OP == 4'b1111), 0, 0, wb, 0, c, 0, 0);
          end
          2'b01: begin
            if (!blk) cur = mk(1, 0, 1, S, !S, S, 0, 4'b0010, 0, 0);
            else begin
              k = 0;
              for (int i = 0; i < W; i++)
                if (reg_list[i]) begin
                  pend.push_back(mk(1, 0, 1, S, !S, S, 0, 4'b0010, i, k));
                  k++;
                end
              if (pend.size() != 0) cur = pend.pop_front();
            end
          end
          2'b10: cur = mk(1, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, 32'({valid_out, SR_update, with_src1, MEM_R, MEM_W, WB_EN, B,
                  EX_CMD, blk_reg, blk_off, busy}),
             32'({cur, pend.size() != 0}));
  endtask

  task automatic drv(input bit v, input logic [1:0] m, input logic [3:0] op,
                     input bit s, input bit b, input logic [W-1:0] rl);
    valid_in = v; mode = m; OP = op; S = s; blk = b; reg_list = rl;
  endtask

  logic [3:0] ops [12] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                           4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b0011};
  int bc;

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    drv(1, 2'b00, 4'b0100, 0, 0, '0);
    step("rst0");
    step("rst1");
    rst = 1'b1;
    step("rst_rel_add");

    foreach (ops[i]) begin
      drv(1, 2'b00, ops[i], 1, 0, '0);
      step("decode");
    end

    // LDM: four beats, junk inputs while busy.
    drv(1, 2'b01, 4'b0000, 1, 1, 16'b1000_0000_0010_0101);
    bc = 0;
    step("ldm");
    bc += int'(busy);
    for (int i = 0; i < 3; i++) begin
      drv(1, 2'(i), 4'(i + 3), i[0], 1, 16'hffff);
      step("ldm_beat");
      bc += int'(busy);
    end
    chk("ldm_busy_cycles", bc, 3);
    drv(0, 2'b00, 4'b0000, 0, 0, '0);
    step("idle");

    // STM single bit, then empty list.
    drv(1, 2'b01, 4'b0000, 0, 1, 16'h0001);
    step("stm1");
    drv(1, 2'b01, 4'b0000, 0, 1, 16'h0000);
    step("blk_empty");

    // Freeze at beat 2 of the LDM.
    drv(1, 2'b01, 4'b0000, 1, 1, 16'b1000_0000_0010_0101);
    step("frz_b1");
    drv(0, 2'b00, 4'b0000, 0, 0, '0);
    step("frz_b2");
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step("frz_hold");
    freeze = 1'b0;
    step("frz_b3");
    chk("resume_reg", 32'(blk_reg), 32'd5);
    step("frz_b4");
    step("frz_done");

    // Flush together with freeze at beat 1, then a branch.
    drv(1, 2'b01, 4'b0000, 1, 1, 16'b1000_0000_0010_0101);
    step("fl_b1");
    flush = 1'b1; freeze = 1'b1;
    step("flush");
    flush = 1'b0; freeze = 1'b0;
    drv(1, 2'b10, 4'b0000, 0, 0, '0);
    step("branch");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] rl;
      case ($urandom_range(0, 3))
        0: rl = '0;
        1: rl = W'(1) << $urandom_range(0, W - 1);
        2: rl = W'($urandom);
        default: rl = W'($urandom) & W'($urandom);
      endcase
      rst    = ($urandom_range(0, 49) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      drv($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 0), rl);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
